// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mips_pkg
// Purpose : Shared definitions for the instruction fetch path: next-PC select
//           encodings, instruction field bit positions, fetch state encoding
//           and the default reset PC.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Next-PC select encodings driven by the controller on PCSrc
  localparam logic [1:0] PC_SEQ = 2'b00;  // pc + 4
  localparam logic [1:0] PC_BR  = 2'b01;  // pc + 4 + (sext(imm16) << 2)
  localparam logic [1:0] PC_JR  = 2'b10;  // register target
  localparam logic [1:0] PC_J   = 2'b11;  // pseudo-direct jump

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JIDX_W = 26;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Fetch handshake state
  typedef enum logic [0:0] {
    FS_IDLE = 1'b0,
    FS_WAIT = 1'b1
  } fetch_state_e;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/inst_fetch_unit_pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module  : pc_next_mux
// Purpose : Combinational next-PC selection for the fetch unit.
// Ports   : pc_i        current PC
//           pcsrc_i     select (PC_SEQ / PC_BR / PC_JR / PC_J)
//           imm16_i     branch offset in words (sign-extended here)
//           jidx_i      26-bit jump word index
//           rs_data_i   register jump target
//           pc_plus4_o  pc_i + 4
//           next_pc_o   selected target, always word aligned
// Revision: 1.0 - initial release
// ============================================================================
module pc_next_mux
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [1:0]        pcsrc_i,
  input  logic [15:0]       imm16_i,
  input  logic [JIDX_W-1:0] jidx_i,
  input  logic [31:0]       rs_data_i,
  output logic [ADDR_W-1:0] pc_plus4_o,
  output logic [ADDR_W-1:0] next_pc_o
);

  logic [ADDR_W-1:0] w_br_off;
  logic [ADDR_W-1:0] w_sel;

  assign pc_plus4_o = pc_i + ADDR_W'(4);
  assign w_br_off   = {{(ADDR_W-18){imm16_i[15]}}, imm16_i, 2'b00};

  always_comb begin
    w_sel = pc_plus4_o;
    unique case (pcsrc_i)
      PC_SEQ:  w_sel = pc_plus4_o;
      PC_BR:   w_sel = pc_plus4_o + w_br_off;
      PC_JR:   w_sel = rs_data_i[ADDR_W-1:0];
      PC_J:    w_sel = {pc_plus4_o[ADDR_W-1:28], jidx_i, 2'b00};
      default: w_sel = pc_plus4_o;
    endcase
  end

  // A misaligned jr target is silently realigned rather than trapped.
  assign next_pc_o = w_sel & ~ADDR_W'(3);

endmodule : pc_next_mux
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : inst_fetch_unit
// Purpose : Holds PC and IR, runs a request/valid handshake to a variable
//           latency instruction memory, and decodes the IR fields.
// Ports   : clk, reset         clock / async active-high reset
//           PCWre, PCSrc       PC write enable and next-PC select
//           IRWre, InsMemRW    fetch request level / memory read enable
//           rs_data            jr target
//           imem_req/addr      one-cycle read strobe, latched fetch address
//           imem_rdata/valid   memory response
//           pc, pc_plus4, ir   architectural state
//           opcode/rs/rt/rd/imm16  IR field decode
//           ir_done            one-cycle pulse when IR loads
//           fetch_busy         fetch outstanding or about to be issued
// Revision: 1.0 - initial release
// ============================================================================
module inst_fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              PCWre,
  input  logic [1:0]        PCSrc,
  input  logic              IRWre,
  input  logic              InsMemRW,
  input  logic [31:0]       rs_data,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [31:0]       ir,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic              ir_done,
  output logic              fetch_busy
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] next_pc;
  logic              start_fetch;

  pc_next_mux #(
    .ADDR_W (ADDR_W)
  ) u_pc_next_mux (
    .pc_i       (pc_q),
    .pcsrc_i    (PCSrc),
    .imm16_i    (ir_q[IMM_HI:IMM_LO]),
    .jidx_i     (ir_q[JIDX_W-1:0]),
    .rs_data_i  (rs_data),
    .pc_plus4_o (pc_plus4),
    .next_pc_o  (next_pc)
  );

  // The done pulse masks a request so a controller still holding IRWre in
  // that cycle does not immediately launch a second fetch.
  assign start_fetch = (state_q == FS_IDLE) && IRWre && InsMemRW && !done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FS_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = PCWre ? next_pc : pc_q;
    ir_d    = ir_q;
    req_d   = 1'b0;
    addr_d  = addr_q;
    done_d  = 1'b0;
    unique case (state_q)
      FS_IDLE: begin
        // Responses arriving here are stale and are dropped.
        if (start_fetch) begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (imem_valid) begin
          ir_d    = imem_rdata;
          done_d  = 1'b1;
          state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  assign pc         = pc_q;
  assign ir         = ir_q;
  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ir_done    = done_q;
  assign fetch_busy = (state_q == FS_WAIT) || start_fetch;

  assign opcode = ir_q[OPC_HI:OPC_LO];
  assign rs     = ir_q[RS_HI:RS_LO];
  assign rt     = ir_q[RT_HI:RT_LO];
  assign rd     = ir_q[RD_HI:RD_LO];
  assign imm16  = ir_q[IMM_HI:IMM_LO];

endmodule : inst_fetch_unit
`default_nettype wire

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Upstream neighbour of the multicycle controller.
- Holds the PC and the instruction register (IR), issues instruction-memory reads, and decodes IR fields.
- Its opcode output feeds the controller's opcode input.
- Consumes the controller's PCWre, PCSrc, IRWre and InsMemRW.
- Instruction memory has variable latency, so fetch runs a request/valid handshake and reports busy back to the controller.

Parameters:
- RESET_PC, 32'h0000_0000: PC value after reset; bits [1:0] must be 0.
- ADDR_W, 32: PC and instruction-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  async active-high reset.
- PCWre  in  1  PC write enable from controller.
- PCSrc  in  2  next-PC select: 00 PC+4, 01 branch, 10 jr, 11 jump.
- IRWre  in  1  fetch request level from controller; held until ir_done.
- InsMemRW  in  1  instruction-memory read enable; 0 blocks new requests.
- rs_data  in  32  register-file rs read data, used as the jr target.
- imem_req  out  1  one-cycle read strobe.
- imem_addr  out  ADDR_W  registered fetch address.
- imem_rdata  in  32  instruction word.
- imem_valid  in  1  imem_rdata valid this cycle.
- pc  out  ADDR_W  current PC.
- pc_plus4  out  ADDR_W  pc+4.
- ir  out  32  instruction register.
- opcode  out  6  ir[31:26].
- rs  out  5  ir[25:21].
- rt  out  5  ir[20:16].
- rd  out  5  ir[15:11].
- imm16  out  16  ir[15:0].
- ir_done  out  1  one-cycle pulse when IR is loaded.
- fetch_busy  out  1  fetch outstanding.

Behaviour:
- Reset (async, active-high):
  - pc = RESET_PC, ir = 32'h0, state = IDLE.
  - imem_req = 0, imem_addr = RESET_PC, ir_done = 0.
- PC update: on a clk edge with PCWre=1, pc <= next_pc. next_pc by PCSrc:
  - 00: pc+4.
  - 01: pc+4 + (sign-extend(imm16) << 2).
  - 10: rs_data.
  - 11: {pc_plus4[31:28], ir[25:0], 2'b00}.
- next_pc[1:0] is always forced to 00. Arithmetic is mod 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.
- The branch decision (zero) is the controller's job. This block only muxes per PCSrc.
- PCWre=0: pc holds.
- Fetch FSM, states IDLE and WAIT:
  - IDLE with IRWre=1 and InsMemRW=1: next cycle imem_req=1 for exactly one cycle, imem_addr<=pc, go to WAIT.
  - IDLE otherwise: stay. imem_valid is ignored in IDLE (stray or late responses are dropped).
  - WAIT with imem_valid=1: ir<=imem_rdata, ir_done=1 next cycle, go to IDLE.
  - WAIT with imem_valid=0: stay, with imem_addr held.
- Minimum latency: IRWre high at edge N gives imem_req at N+1. With imem_valid at N+1, ir and ir_done are updated at N+2.
- Back-to-back fetches: at least one IDLE cycle separates them. IRWre still high in the cycle ir_done pulses does not re-request; the controller must drop IRWre on ir_done.
- fetch_busy = (state==WAIT) | (state==IDLE & IRWre & InsMemRW & ~ir_done).
- PCWre during WAIT: pc updates normally. The outstanding fetch uses the latched imem_addr and is unaffected.
- PCWre and imem_valid in the same cycle: both take effect independently.
- Reset asserted in WAIT: return to IDLE immediately. A subsequent imem_valid is discarded and ir keeps 0.
- IR field outputs are combinational from the registered ir. pc_plus4 is combinational from pc.

Decomposition:
- Shared package mips_pkg:
  - PCSrc encodings PC_SEQ=2'b00, PC_BR=2'b01, PC_JR=2'b10, PC_J=2'b11.
  - Opcode field slice constants.
  - Fetch state enum (IDLE, WAIT).
  - Default RESET_PC.
- One sub-module, pc_next_mux: combinational next-PC computation from pc, imm16, jump index and rs_data. PC/IR registers and the FSM stay in the top.

Test Plan:
- Reset then IRWre=1, InsMemRW=1, imem_valid one cycle after imem_req with rdata 32'h8C22_0004 -> imem_addr=0, ir=32'h8C22_0004, opcode=6'h23, rs=1, rt=2, imm16=4, single ir_done pulse.
- pc=32'h0000_0040, ir imm16=16'hFFFE, PCSrc=01, PCWre=1 -> pc=32'h0000_003C. Same with PCSrc=00 -> 32'h0000_0044.
- pc=32'h1000_0010, ir[25:0]=26'h000_0040, PCSrc=11 -> pc=32'h1000_0100. PCSrc=10 with rs_data=32'h0000_0203 -> pc=32'h0000_0200.
- imem_valid delayed 5 cycles -> fetch_busy=1 throughout WAIT, imem_addr stable, imem_req only one cycle. InsMemRW=0 with IRWre=1 -> no imem_req.
- Reset asserted mid-WAIT, imem_valid arrives 2 cycles after reset release -> ir stays 0, no ir_done, pc=RESET_PC.
- PCWre with PCSrc=00 in the same cycle as imem_valid in WAIT -> pc advances by 4 and ir loads the word fetched from the old address. pc=32'hFFFF_FFFC with PCSrc=00 -> pc=0.
